// File: rtl/canakari_pkg.sv
// Shared CANakari constants and the bitwise majority helper used by the voter.
package canakari_pkg;
  localparam int CAN_DATA_W    = 5;
  localparam int CAN_REC_DEPTH = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/tmr_voter.sv
// Bitwise 2-of-3 majority voter for triplicated state registers.
module tmr_voter
  import canakari_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : gen_bit
      assign y[gi] = maj3(a[gi], b[gi], c[gi]);
    end
  endgenerate
endmodule

// File: rtl/canakari_rec_fifo.sv
// DEPTH-entry first-word-fall-through receive FIFO with level and sticky overflow.
// Define CANAKARI_FIFO_TMR_EN to triplicate pointers, level and overflow with majority voting.
module canakari_rec_fifo
  import canakari_pkg::*;
#(
  parameter int WIDTH = CAN_DATA_W,
  parameter int DEPTH = CAN_REC_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         buffer_en,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         rd_en,
  input  logic                         ovf_clr,
  output logic [WIDTH-1:0]             data_out,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0] wr_ptr_v, rd_ptr_v, wr_ptr_next, rd_ptr_next;
  logic [CNT_W-1:0] level_v, level_next;
  logic             ovf_v, ovf_next;
  logic             empty_i, full_i, push, pop, drop;

  logic [WIDTH-1:0] mem [DEPTH];

  // Wrap bit distinguishes full from empty when the address bits coincide.
  assign empty_i = (wr_ptr_v == rd_ptr_v);
  assign full_i  = (wr_ptr_v[ADDR_W-1:0] == rd_ptr_v[ADDR_W-1:0]) &&
                   (wr_ptr_v[PTR_W-1] != rd_ptr_v[PTR_W-1]);

  assign push = buffer_en && (!full_i || rd_en);
  assign pop  = rd_en && !empty_i;
  assign drop = buffer_en && full_i && !rd_en;

  always_comb begin
    wr_ptr_next = wr_ptr_v;
    rd_ptr_next = rd_ptr_v;
    level_next  = level_v;
    ovf_next    = ovf_v;
    if (push) wr_ptr_next = wr_ptr_v + PTR_W'(1);
    if (pop)  rd_ptr_next = rd_ptr_v + PTR_W'(1);
    if (push && !pop)      level_next = level_v + CNT_W'(1);
    else if (pop && !push) level_next = level_v - CNT_W'(1);
    if (drop)         ovf_next = 1'b1;
    else if (ovf_clr) ovf_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr_v[ADDR_W-1:0]] <= data_in;
  end

`ifdef CANAKARI_FIFO_TMR_EN
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gen_copy
      logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
      logic [CNT_W-1:0] level_r;
      logic             ovf_r;
      // Every copy reloads from the voted next state, so one upset heals in a cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_r <= '0;
          rd_ptr_r <= '0;
          level_r  <= '0;
          ovf_r    <= 1'b0;
        end else begin
          wr_ptr_r <= wr_ptr_next;
          rd_ptr_r <= rd_ptr_next;
          level_r  <= level_next;
          ovf_r    <= ovf_next;
        end
      end
    end
  endgenerate

  tmr_voter #(.W(PTR_W)) u_vote_wr (
    .a(gen_copy[0].wr_ptr_r), .b(gen_copy[1].wr_ptr_r), .c(gen_copy[2].wr_ptr_r), .y(wr_ptr_v)
  );
  tmr_voter #(.W(PTR_W)) u_vote_rd (
    .a(gen_copy[0].rd_ptr_r), .b(gen_copy[1].rd_ptr_r), .c(gen_copy[2].rd_ptr_r), .y(rd_ptr_v)
  );
  tmr_voter #(.W(CNT_W)) u_vote_lvl (
    .a(gen_copy[0].level_r), .b(gen_copy[1].level_r), .c(gen_copy[2].level_r), .y(level_v)
  );
  tmr_voter #(.W(1)) u_vote_ovf (
    .a(gen_copy[0].ovf_r), .b(gen_copy[1].ovf_r), .c(gen_copy[2].ovf_r), .y(ovf_v)
  );
`else
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] level_r;
  logic             ovf_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      ovf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_next;
      rd_ptr_r <= rd_ptr_next;
      level_r  <= level_next;
      ovf_r    <= ovf_next;
    end
  end

  assign wr_ptr_v = wr_ptr_r;
  assign rd_ptr_v = rd_ptr_r;
  assign level_v  = level_r;
  assign ovf_v    = ovf_r;
`endif

  assign data_out = empty_i ? '0 : mem[rd_ptr_v[ADDR_W-1:0]];
  assign empty    = empty_i;
  assign full     = full_i;
  assign level    = level_v;
  assign overflow = ovf_v;
endmodule

// File: tb/tb_canakari_rec_fifo.sv
// Randomised and directed bench for canakari_rec_fifo against a queue-based reference model.
module tb_canakari_rec_fifo;
  localparam int WIDTH = 5;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, buffer_en, rd_en, ovf_clr;
  logic [WIDTH-1:0] data_in, data_out;
  logic             empty, full, overflow;
  logic [CNT_W-1:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  int q[$];
  bit m_ovf    = 1'b0;
  int m_rd_cnt = 0;

  always #5 clk = ~clk;

  canakari_rec_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .buffer_en(buffer_en), .data_in(data_in), .rd_en(rd_en),
    .ovf_clr(ovf_clr), .data_out(data_out), .empty(empty), .full(full),
    .level(level), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int head;
    head = (q.size() > 0) ? q[0] : 0;
    check({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
    check({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
    check({tag, ".level"},    32'(level),    32'(q.size()));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".data_out"}, 32'(data_out), 32'(head));
  endtask

  // One clock transaction: drive on the falling edge, update the model and compare after the rising edge.
  task automatic step(input string tag, input bit r, input bit be, input logic [WIDTH-1:0] din,
                      input bit rd, input bit clr);
    int  n;
    bit  do_pop, do_push, do_drop;
    @(negedge clk);
    rst = r; buffer_en = be; data_in = din; rd_en = rd; ovf_clr = clr;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_ovf    = 1'b0;
      m_rd_cnt = 0;
    end else begin
      n       = q.size();
      do_pop  = rd && (n > 0);
      do_push = be && ((n < DEPTH) || rd);
      do_drop = be && (n == DEPTH) && !rd;
      if (do_pop) begin
        void'(q.pop_front());
        m_rd_cnt = (m_rd_cnt + 1) % (2 * DEPTH);
      end
      if (do_push) q.push_back(int'(din));
      if (do_drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    $display("%-8s rst=%0d be=%0d din=%02h rd=%0d clr=%0d -> level=%0d dout=%02h ovf=%0d",
             tag, r, be, din, rd, clr, level, data_out, overflow);
    check_outputs(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    rst = 1'b1; buffer_en = 1'b0; data_in = '0; rd_en = 1'b0; ovf_clr = 1'b0;

    // Reset wins over a write strobe.
    step("reset", 1, 1, 5'h1F, 0, 0);
    step("reset", 1, 1, 5'h1F, 0, 0);

    for (int i = 1; i <= DEPTH; i++) step("fill", 0, 1, WIDTH'(i), 0, 0);
    check("fill_head", 32'(data_out), 32'h01);
    step("drop", 0, 1, 5'h1F, 0, 0);
    check("drop_ovf", 32'(overflow), 32'h1);
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 0, 5'h00, 1, 0);
    check("drain_empty", 32'(empty), 32'h1);
    step("clr", 0, 0, 5'h00, 0, 1);

    for (int i = 1; i <= DEPTH; i++) step("fill", 0, 1, WIDTH'(i + 8), 0, 0);
    step("fullrw", 0, 1, 5'h0A, 1, 0);
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 0, 5'h00, 1, 0);

    step("emptyrw", 0, 1, 5'h15, 1, 0);
    check("emptyrw_dout", 32'(data_out), 32'h15);
    step("pop", 0, 0, 5'h00, 1, 0);
    step("popempt", 0, 0, 5'h00, 1, 0);

    step("push", 0, 1, 5'h03, 0, 0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      d = WIDTH'($urandom);
      step("wrap", 0, 1, d, 1, 0);
    end
    step("push", 0, 1, 5'h07, 0, 0);
    check("mid_level", 32'(level), 32'h2);
    step("midrst", 1, 0, 5'h00, 0, 0);

    // Clear and a fresh drop in the same cycle: the drop wins.
    for (int i = 0; i < DEPTH; i++) step("fill", 0, 1, WIDTH'(i + 20), 0, 0);
    step("clrdrop", 0, 1, 5'h11, 0, 1);
    check("clrdrop_ovf", 32'(overflow), 32'h1);
    step("clr", 0, 0, 5'h00, 0, 1);
    step("midrst", 1, 0, 5'h00, 0, 0);

`ifdef CANAKARI_FIFO_TMR_EN
    begin
      logic [PTR_W-1:0] bad;
      step("push", 0, 1, 5'h0C, 0, 0);
      step("push", 0, 1, 5'h0D, 0, 0);
      step("pop", 0, 0, 5'h00, 1, 0);
      step("idle", 0, 0, 5'h00, 0, 0);
      bad = PTR_W'(m_rd_cnt) ^ PTR_W'(3'b101);
      @(negedge clk);
      force dut.gen_copy[1].rd_ptr_r = bad;
      #1;
      check_outputs("upset");
      @(posedge clk);
      #1;
      release dut.gen_copy[1].rd_ptr_r;
      @(posedge clk);
      #1;
      check("tmr_heal", 32'(dut.gen_copy[1].rd_ptr_r), 32'(m_rd_cnt));
      check_outputs("healed");
    end
`endif

    for (int i = 0; i < 400; i++) begin
      bit r, be, rd, clr;
      r   = ($urandom_range(0, 59) == 0);
      be  = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd  = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      d   = WIDTH'($urandom);
      step("rand", r, be, d, rd, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
